alu_iter: RTL
=============

// Module: alu_iter
// PURPOSE
//  Multi-cycle 8-bit execute stage directly downstream of the register file read ports.
//  - Latches the operand pair (datA/datB) and the destination pointer when an op is issued.
//  - Computes single-cycle ops immediately; shifts and multiply iterate one bit per cycle.
//  - Drives the register file write port (wr_en/wr_addr/dat_in) and the condition flags.
// PARAMETERS
//  W    8  data width (datapath, operands, result)
//  pw   4  register address pointer width; must match the register file
// PORTS
//  clk      in   1     rising-edge clock
//  rst_n    in   1     asynchronous active-low reset
//  start    in   1     synchronous abort/clear; same pulse that clears the register file
//  go       in   1     issue request; accepted only when busy==0
//  op       in   3     000 ADD, 001 SUB, 010 AND, 011 XOR, 100 SHL, 101 SHR, 110 MUL, 111 CMP
//  datA     in   W     operand A from register file read port A
//  datB     in   W     operand B from register file read port B (shift amount = datB[2:0])
//  dst      in   pw    destination register pointer
//  busy     out  1     high while state != IDLE
//  done     out  1     one-cycle pulse in WB
//  wr_en    out  1     register file write enable; high only in WB, and never for CMP
//  wr_addr  out  pw    latched dst; valid while wr_en is high
//  dat_out  out  W     result; connects to register file dat_in
//  zero     out  1     flag: last result == 0
//  carry    out  1     flag: see arithmetic rules
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; busy, done, wr_en, wr_addr, dat_out, zero, carry all 0.
//  - FSM states: IDLE, CALC, WB. busy = (state != IDLE).
//  - Accept: in IDLE with go=1 (and start=0), latch op, datA, datB, dst, and iteration count k on that edge.
//    - go while busy is ignored. The operands are held internally, so register file outputs may change freely.
//  - Next state after accept:
//    - Single-cycle ops (ADD/SUB/AND/XOR/CMP), and SHL/SHR with k=0, go straight to WB.
//    - Otherwise go to CALC.
//  - k values: SHL/SHR use k = datB[2:0]; MUL uses k = 8.
//  - CALC: one shift or shift-add step per cycle, k cycles, then WB.
//  - WB: lasts exactly 1 cycle, then IDLE. In WB: done=1; wr_en=1 unless op==CMP; flags take their new values.
//  - Latency from the accepting edge N: WB occupies the cycle after edge N+k (k=0 for single-cycle ops).
//    The register file captures the result on the edge that ends WB.
//  - Back-to-back: the next go can be accepted at the edge ending WB+1 (first IDLE cycle); no overlap.
//  - dat_out and wr_addr hold their last values outside WB; only wr_en qualifies them.
//  - Arithmetic is modulo 2^W.
//    - ADD: carry = carry-out.
//    - SUB/CMP: result = A-B; carry = borrow (A<B unsigned).
//    - CMP: updates zero and carry only; dat_out is unchanged and there is no write.
//    - AND/XOR: carry = 0.
//    - SHL/SHR: logical shifts, zero fill; carry = last bit shifted out; carry = 0 when k=0.
//    - MUL: unsigned shift-add; dat_out = low W bits; carry = (high W bits != 0).
//    - zero = (result == 0) for every op.
//  - start=1 (sync, highest priority after rst_n): abort any op, state=IDLE, clear all outputs, no write.
//    go in the same cycle as start is dropped.
//  - Reset or start mid-CALC: no partial write ever reaches the register file.
// TESTING
//  1. ADD A=FF B=01 dst=3, go at edge 0 -> WB cycle after edge 0: wr_en=1, wr_addr=3, dat_out=00, zero=1, carry=1, done=1.
//  2. MUL A=10 B=11 -> busy for 9 cycles; WB after edge 8: dat_out=10, carry=1, zero=0.
//  3. SHL A=81 B=03 -> 3 CALC cycles, dat_out=08, carry=0. SHR A=81 B=00 -> direct WB, dat_out=81, carry=0.
//  4. CMP A=05 B=07 -> done=1, wr_en stays 0, carry=1, zero=0, dat_out unchanged.
//  5. MUL issued; go with new operands during CALC -> ignored, original result written.
//     Then a second MUL issued; rst_n=0 at its 4th CALC cycle -> all outputs 0 immediately, no wr_en pulse.
//  6. start=1 together with go in IDLE -> op not accepted, busy stays 0. Back-to-back ADD issued in first IDLE cycle -> accepted.

Source files
------------

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle 8-bit execute stage sitting behind the register file read ports.
// Single-cycle ops resolve on the accepting edge. Shifts and multiply iterate one bit per
// cycle in CALC, counted down from k to the terminal count.
//
//   state | meaning
//   IDLE  | waiting for go; the only state that accepts an issue
//   CALC  | one shift or shift-add step per cycle, k cycles in total
//   WB    | one cycle: done pulse, register file write (except CMP), flags valid
module alu_iter #(
  parameter int W  = 8,
  parameter int pw = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          go,
  input  logic [2:0]    op,
  input  logic [W-1:0]  datA,
  input  logic [W-1:0]  datB,
  input  logic [pw-1:0] dst,
  output logic          busy,
  output logic          done,
  output logic          wr_en,
  output logic [pw-1:0] wr_addr,
  output logic [W-1:0]  dat_out,
  output logic          zero,
  output logic          carry
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, WB} state_t;

  state_t          state, state_nxt;
  logic [2:0]      op_q;
  logic [pw-1:0]   dst_q;
  logic [W-1:0]    mcand;
  // low half holds the shift operand or multiplier; high half accumulates the product
  logic [2*W-1:0]  prod;
  logic [3:0]      cnt;

  logic [3:0]      k_in;
  logic            direct;
  logic [W-1:0]    sc_res;
  logic            sc_c;
  logic [2*W-1:0]  step_prod;
  logic            step_c;
  logic [W:0]      mul_sum;
  logic [W-1:0]    step_res;
  logic            step_cy;

  // Iteration count and whether the op can skip CALC entirely
  always_comb begin
    k_in   = 4'd0;
    direct = 1'b1;
    case (op)
      OP_SHL, OP_SHR: begin
        k_in   = {1'b0, datB[2:0]};
        direct = (datB[2:0] == 3'd0);
      end
      OP_MUL: begin
        k_in   = 4'd8;
        direct = 1'b0;
      end
      default: begin
        k_in   = 4'd0;
        direct = 1'b1;
      end
    endcase
  end

  // Single-cycle result straight from the read ports; zero-length shifts pass A through
  always_comb begin
    sc_res = datA;
    sc_c   = 1'b0;
    case (op)
      OP_ADD:         {sc_c, sc_res} = {1'b0, datA} + {1'b0, datB};
      OP_SUB, OP_CMP: begin
        sc_res = datA - datB;
        sc_c   = (datA < datB);
      end
      OP_AND:         sc_res = datA & datB;
      OP_XOR:         sc_res = datA ^ datB;
      default: begin
        sc_res = datA;
        sc_c   = 1'b0;
      end
    endcase
  end

  // One iteration step on the latched operands
  always_comb begin
    step_prod = prod;
    step_c    = 1'b0;
    mul_sum   = {(W+1){1'b0}};
    case (op_q)
      OP_SHL: begin
        step_prod[W-1:0] = {prod[W-2:0], 1'b0};
        step_c           = prod[W-1];
      end
      OP_SHR: begin
        step_prod[W-1:0] = {1'b0, prod[W-1:1]};
        step_c           = prod[0];
      end
      default: begin
        mul_sum   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : {(W+1){1'b0}});
        step_prod = {mul_sum, prod[W-1:1]};
      end
    endcase
    step_res = step_prod[W-1:0];
    step_cy  = (op_q == OP_MUL) ? (|step_prod[2*W-1:W]) : step_c;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and status outputs; start overrides everything
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == WB);
    wr_en     = (state == WB) && (op_q != OP_CMP);
    case (state)
      IDLE:    if (go) state_nxt = direct ? WB : CALC;
      CALC:    if (cnt == 4'd1) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (start) state_nxt = IDLE;
  end

  // Operand latch, iteration datapath and result/flag registers loaded on entry to WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_ADD;
      dst_q   <= '0;
      mcand   <= '0;
      prod    <= '0;
      cnt     <= 4'd0;
      wr_addr <= '0;
      dat_out <= '0;
      zero    <= 1'b0;
      carry   <= 1'b0;
    end else if (start) begin
      cnt     <= 4'd0;
      prod    <= '0;
      wr_addr <= '0;
      dat_out <= '0;
      zero    <= 1'b0;
      carry   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            op_q  <= op;
            dst_q <= dst;
            mcand <= datA;
            cnt   <= k_in;
            prod  <= (op == OP_MUL) ? {{W{1'b0}}, datB} : {{W{1'b0}}, datA};
            if (direct) begin
              if (op != OP_CMP) dat_out <= sc_res;
              zero    <= (sc_res == '0);
              carry   <= sc_c;
              wr_addr <= dst;
            end
          end
        end
        CALC: begin
          prod <= step_prod;
          cnt  <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            dat_out <= step_res;
            zero    <= (step_res == '0);
            carry   <= step_cy;
            wr_addr <= dst_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
